// File: rtl/rotsq_pkg.sv
// Shared constants for the rotating-square display demo: active-low segment
// patterns and the position-to-digit decode.
package rotsq_pkg;
  localparam logic [7:0] SSEG_UPPER = 8'h9C;
  localparam logic [7:0] SSEG_LOWER = 8'hA3;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam int         NUM_POS    = 8;
  localparam int         POS_W      = $clog2(NUM_POS);

  // Top row runs left to right (digit 3..0), bottom row runs back right to left.
  function automatic logic [7:0] pos_pat(input logic [POS_W-1:0] pos, input logic [1:0] dig);
    logic [7:0] pat;
    pat = SSEG_BLANK;
    if (!pos[2]) begin
      if (dig == ~pos[1:0]) pat = SSEG_UPPER;
    end else begin
      if (dig == pos[1:0]) pat = SSEG_LOWER;
    end
    return pat;
  endfunction
endpackage

// File: rtl/disp_mux4.sv
// Four-digit time-multiplexer: free-running refresh counter whose top two bits
// pick the active (low) anode and the matching segment pattern.
module disp_mux4 #(
  parameter int REFRESH_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0][7:0] pats_i,
  output logic [3:0]      an,
  output logic [7:0]      sseg
);
  logic [REFRESH_BITS-1:0] rcnt_q, rcnt_d;
  logic [1:0]              sel;

  always_comb begin
    rcnt_d = rcnt_q + REFRESH_BITS'(1);
    sel    = rcnt_q[REFRESH_BITS-1 -: 2];
    an     = ~(4'b0001 << sel);
    sseg   = pats_i[sel];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end
endmodule

// File: rtl/rotating_square_ctrl.sv
// Rotating half-square demo: step divider, 8-position square register and
// per-digit pattern decode, feeding the 4-digit display multiplexer.
module rotating_square_ctrl
  import rotsq_pkg::*;
#(
  parameter int ROT_DIV      = 10,
  parameter int REFRESH_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cw,
  output logic [3:0] an,
  output logic [7:0] sseg
);
  localparam int                DIV_W    = $clog2(ROT_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ROT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             tick;
  logic [3:0][7:0]  pats;
  logic [7:0]       sseg_pats_0, sseg_pats_1, sseg_pats_2, sseg_pats_3;

  // Divider is held at zero while disabled so re-enabling gives a full interval.
  always_comb begin
    tick  = en && (div_q == DIV_LAST);
    div_d = div_q;
    pos_d = pos_q;
    if (!en) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
      pos_d = cw ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      pos_q <= '0;
    end else begin
      div_q <= div_d;
      pos_q <= pos_d;
    end
  end

  always_comb begin
    for (int d = 0; d < 4; d++)
      pats[d] = en ? pos_pat(pos_q, 2'(d)) : SSEG_BLANK;
  end

  assign sseg_pats_0 = pats[0];
  assign sseg_pats_1 = pats[1];
  assign sseg_pats_2 = pats[2];
  assign sseg_pats_3 = pats[3];

  disp_mux4 #(.REFRESH_BITS(REFRESH_BITS)) u_mux (
    .clk    (clk),
    .reset  (reset),
    .pats_i (pats),
    .an     (an),
    .sseg   (sseg)
  );
endmodule

// File: tb/tb_rotating_square_ctrl.sv
// Directed bench for rotating_square_ctrl at ROT_DIV=10, REFRESH_BITS=2.
module tb_rotating_square_ctrl;
  logic       clk, reset, en, cw;
  logic [3:0] an;
  logic [7:0] sseg;
  int checks = 0;
  int errors = 0;

  localparam logic [3:0] AN_TBL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam int         DIG_OF [8] = '{3, 2, 1, 0, 0, 1, 2, 3};

  rotating_square_ctrl #(.ROT_DIV(10), .REFRESH_BITS(2)) dut (
    .clk(clk), .reset(reset), .en(en), .cw(cw), .an(an), .sseg(sseg)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_pat(input int pos, input int dig, input bit e);
    if (!e || DIG_OF[pos] != dig) return 8'hFF;
    return (pos < 4) ? 8'h9C : 8'hA3;
  endfunction

  function automatic logic [7:0] get_pat(input int d);
    case (d)
      0:       return dut.sseg_pats_0;
      1:       return dut.sseg_pats_1;
      2:       return dut.sseg_pats_2;
      default: return dut.sseg_pats_3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pats(input string tag, input int pos, input bit e);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_pat%0d", tag, d), get_pat(d), exp_pat(pos, d, e));
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Check an/sseg over n cycles; refresh phase is tracked from 'phase'.
  task automatic chk_refresh(input string tag, input int n, input int phase, input int pos, input bit e);
    int sel;
    for (int i = 0; i < n; i++) begin
      clks(1);
      sel = (phase + i + 1) % 4;
      chk($sformatf("%s_an%0d", tag, i), {4'h0, an}, {4'h0, AN_TBL[sel]});
      chk($sformatf("%s_sseg%0d", tag, i), sseg, exp_pat(pos, sel, e));
    end
  endtask

  initial begin
    reset = 1; en = 1; cw = 1;
    #2 reset = 0;
    #2;
    chk("rst_an", {4'h0, an}, 8'h0E);
    chk("rst_sseg", sseg, 8'hFF);
    chk_pats("rst_en1", 0, 1);
    en = 0;
    #1 chk_pats("rst_en0", 0, 0);
    en = 1;
    repeat (2) @(negedge clk);
    reset = 1;

    // refresh sequence from rcnt=0, square at pos0
    chk_refresh("ref", 8, 0, 0, 1);
    clks(1);  chk_pats("pos0_last", 0, 1);
    clks(1);  chk_pats("pos1", 1, 1);
    clks(30); chk_pats("pos4", 4, 1);
    clks(30); chk_pats("pos7", 7, 1);
    clks(10); chk_pats("wrap0", 0, 1);
    clks(20); chk_pats("pos2", 2, 1);

    // disable: blank, hold position, restart with full interval
    en = 0;
    #1 chk_pats("dis", 2, 0);
    chk_refresh("dis", 4, 0, 2, 0);
    clks(246);
    en = 1;
    #1 chk_pats("reen", 2, 1);
    clks(9);  chk_pats("reen_9", 2, 1);
    clks(1);  chk_pats("reen_10", 3, 1);

    // async reset mid-step
    clks(5);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("mid_rst_an", {4'h0, an}, 8'h0E);
    chk("mid_rst_sseg", sseg, 8'hFF);
    chk_pats("mid_rst", 0, 1);
    @(negedge clk);
    reset = 1; cw = 0;

    // counter-clockwise, then mid-interval direction change
    clks(10); chk_pats("ccw7", 7, 1);
    clks(10); chk_pats("ccw6", 6, 1);
    clks(5);
    cw = 1;
    clks(4);  chk_pats("dir_hold", 6, 1);
    clks(1);  chk_pats("dir_cw7", 7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
